// File: rtl/common.sv
// Shared types for the CPU bus logic: bus-cycle commands and the bus-master
// T-state machine, plus small decode helpers used by the bus master.
package common;

    typedef enum logic [2:0] {
        CYC_M1,
        CYC_MEMRD,
        CYC_MEMWR,
        CYC_IORD,
        CYC_IOWR
    } bus_cycle_t;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_T1,
        TS_T2,
        TS_TW,
        TS_T3,
        TS_T4
    } bus_tstate_t;

    // Unused command encodings fall back to a plain memory read.
    function automatic bus_cycle_t decode_cycle(input logic [2:0] raw);
        case (raw)
            3'd0:    return CYC_M1;
            3'd1:    return CYC_MEMRD;
            3'd2:    return CYC_MEMWR;
            3'd3:    return CYC_IORD;
            3'd4:    return CYC_IOWR;
            default: return CYC_MEMRD;
        endcase
    endfunction

    function automatic logic is_io_cycle(input bus_cycle_t c);
        return (c == CYC_IORD) || (c == CYC_IOWR);
    endfunction

    function automatic logic is_read_cycle(input bus_cycle_t c);
        return (c != CYC_MEMWR) && (c != CYC_IOWR);
    endfunction

endpackage

// File: rtl/cpu_bus_master.sv
// Z80-compatible bus-cycle generator: turns req/ack commands into M1, memory
// and I/O cycles, paced by half-T-state strobes from the CPU clock divider.
module cpu_bus_master
    import common::*;
(
    input  logic        clk28,
    input  logic        rst,
    input  logic        t_rise,
    input  logic        t_fall,
    input  logic        req,
    input  logic [2:0]  cmd,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  i_reg,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    input  logic        n_wait,
    output logic        n_m1,
    output logic        n_mreq,
    output logic        n_iorq,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_rfsh
);

    bus_tstate_t state_q, state_d;
    bus_cycle_t  cyc_q, cyc_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [6:0]  r_q, r_d;
    logic        wait_low_q, wait_low_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        n_m1_q, n_m1_d;
    logic        n_mreq_q, n_mreq_d;
    logic        n_iorq_q, n_iorq_d;
    logic        n_rd_q, n_rd_d;
    logic        n_wr_q, n_wr_d;
    logic        n_rfsh_q, n_rfsh_d;

    logic io_cyc;
    logic enter_t3;
    logic start;

    assign io_cyc = is_io_cycle(cyc_q);

    // T3 is entered from T2 (memory, no wait) or from a TW whose WAIT sample was high.
    assign enter_t3 = t_rise && !wait_low_q &&
                      ((state_q == TS_T2 && !io_cyc) || (state_q == TS_TW));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        a_d        = a_q;
        wdata_d    = wdata_q;
        cap_d      = cap_q;
        rdata_d    = rdata_q;
        r_d        = r_q;
        wait_low_d = wait_low_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        ack_d      = 1'b0;
        n_m1_d     = n_m1_q;
        n_mreq_d   = n_mreq_q;
        n_iorq_d   = n_iorq_q;
        n_rd_d     = n_rd_q;
        n_wr_d     = n_wr_q;
        n_rfsh_d   = n_rfsh_q;
        start      = 1'b0;

        case (state_q)
            TS_T1: begin
                if (t_fall) begin
                    if (cyc_q == CYC_M1 || cyc_q == CYC_MEMRD) begin
                        n_mreq_d = 1'b0;
                        n_rd_d   = 1'b0;
                    end else if (cyc_q == CYC_MEMWR) begin
                        n_mreq_d = 1'b0;
                        d_oe_d   = 1'b1;
                        d_out_d  = wdata_q;
                    end else if (cyc_q == CYC_IOWR) begin
                        d_oe_d   = 1'b1;
                        d_out_d  = wdata_q;
                    end
                end
                if (t_rise) begin
                    state_d = TS_T2;
                    if (io_cyc) begin
                        n_iorq_d = 1'b0;
                        if (cyc_q == CYC_IORD) begin
                            n_rd_d = 1'b0;
                        end else begin
                            n_wr_d = 1'b0;
                        end
                    end
                end
            end
            TS_T2: begin
                if (t_fall && !io_cyc) begin
                    wait_low_d = !n_wait;
                    if (cyc_q == CYC_MEMWR) begin
                        n_wr_d = 1'b0;
                    end
                end
                if (t_rise && (io_cyc || wait_low_q)) begin
                    state_d = TS_TW;
                end
            end
            TS_TW: begin
                if (t_fall) begin
                    wait_low_d = !n_wait;
                end
            end
            TS_T3: begin
                if (t_fall) begin
                    if (cyc_q == CYC_M1) begin
                        n_mreq_d = 1'b0;
                    end else begin
                        if (cyc_q == CYC_IORD) begin
                            cap_d = d_in;
                        end
                        n_mreq_d = 1'b1;
                        n_iorq_d = 1'b1;
                        n_rd_d   = 1'b1;
                        n_wr_d   = 1'b1;
                    end
                end
                if (t_rise) begin
                    if (cyc_q == CYC_M1) begin
                        state_d = TS_T4;
                    end else begin
                        state_d = TS_IDLE;
                        ack_d   = 1'b1;
                        d_oe_d  = 1'b0;
                        if (is_read_cycle(cyc_q)) begin
                            rdata_d = cap_q;
                        end
                    end
                end
            end
            TS_T4: begin
                if (t_fall) begin
                    n_mreq_d = 1'b1;
                end
                if (t_rise) begin
                    state_d  = TS_IDLE;
                    ack_d    = 1'b1;
                    d_oe_d   = 1'b0;
                    n_rfsh_d = 1'b1;
                    rdata_d  = cap_q;
                    r_d      = r_q + 7'd1;
                end
            end
            default: begin
            end
        endcase

        // M1 drops its fetch strobes and switches the address to refresh at T3 rise.
        if (enter_t3) begin
            state_d = TS_T3;
            if (cyc_q == CYC_M1 || cyc_q == CYC_MEMRD) begin
                cap_d = d_in;
            end
            if (cyc_q == CYC_M1) begin
                n_m1_d   = 1'b1;
                n_mreq_d = 1'b1;
                n_rd_d   = 1'b1;
                n_rfsh_d = 1'b0;
                a_d      = {i_reg, 1'b0, r_q};
            end
        end

        // A new command is accepted when idle or on the closing edge of the previous cycle.
        if (t_rise && req && (state_q == TS_IDLE || ack_d)) begin
            start   = 1'b1;
            state_d = TS_T1;
            cyc_d   = decode_cycle(cmd);
            a_d     = addr;
            wdata_d = wdata;
            n_m1_d  = (decode_cycle(cmd) == CYC_M1) ? 1'b0 : 1'b1;
        end

        busy_d = (state_d != TS_IDLE) || ack_d || start;
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q    <= TS_IDLE;
            cyc_q      <= CYC_MEMRD;
            a_q        <= 16'h0000;
            wdata_q    <= 8'h00;
            cap_q      <= 8'h00;
            rdata_q    <= 8'h00;
            r_q        <= 7'd0;
            wait_low_q <= 1'b0;
            d_out_q    <= 8'h00;
            d_oe_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            n_m1_q     <= 1'b1;
            n_mreq_q   <= 1'b1;
            n_iorq_q   <= 1'b1;
            n_rd_q     <= 1'b1;
            n_wr_q     <= 1'b1;
            n_rfsh_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            a_q        <= a_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
            r_q        <= r_d;
            wait_low_q <= wait_low_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            n_m1_q     <= n_m1_d;
            n_mreq_q   <= n_mreq_d;
            n_iorq_q   <= n_iorq_d;
            n_rd_q     <= n_rd_d;
            n_wr_q     <= n_wr_d;
            n_rfsh_q   <= n_rfsh_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign a      = a_q;
    assign d_out  = d_out_q;
    assign d_oe   = d_oe_q;
    assign n_m1   = n_m1_q;
    assign n_mreq = n_mreq_q;
    assign n_iorq = n_iorq_q;
    assign n_rd   = n_rd_q;
    assign n_wr   = n_wr_q;
    assign n_rfsh = n_rfsh_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: walks each bus cycle half-T-state by
// half-T-state and compares strobes, state and data against hand-derived tables.
module tb_cpu_bus_master;
    import common::*;

    logic        clk28 = 1'b0;
    logic        rst = 1'b1;
    logic        t_rise = 1'b0;
    logic        t_fall = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  i_reg = 8'h00;
    logic [7:0]  d_in = 8'h00;
    logic        n_wait = 1'b1;
    logic        ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh;
    logic [5:0]  strb;

    int checks = 0;
    int fails = 0;
    int phase = 0;

    assign strb = {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh};

    cpu_bus_master dut (
        .clk28(clk28), .rst(rst), .t_rise(t_rise), .t_fall(t_fall),
        .req(req), .cmd(cmd), .addr(addr), .wdata(wdata), .i_reg(i_reg),
        .ack(ack), .rdata(rdata), .busy(busy), .a(a), .d_out(d_out),
        .d_oe(d_oe), .d_in(d_in), .n_wait(n_wait), .n_m1(n_m1),
        .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
        .n_rfsh(n_rfsh)
    );

    initial forever #5 clk28 = ~clk28;

    // Divider model: rise, idle, fall, idle -- one T-state every four clk28.
    initial forever begin
        @(negedge clk28);
        phase  = (phase + 1) % 4;
        t_rise = (phase == 0);
        t_fall = (phase == 2);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic next_edge(output logic rise_seen);
        logic seen;
        seen = 1'b0;
        rise_seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (t_rise || t_fall) begin
                seen = 1'b1;
                rise_seen = t_rise;
            end
        end
    endtask

    task automatic begin_cycle(input logic [2:0] c, input logic [15:0] ad,
                               input logic [7:0] wd, input logic hold);
        logic rs;
        rs = 1'b0;
        cmd = c;
        addr = ad;
        wdata = wd;
        req = 1'b1;
        for (int i = 0; i < 4 && !rs; i++) next_edge(rs);
        if (!hold) req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (strb !== 6'h3F) begin fails++; $display("FAIL reset_strobes: got %b want %b", strb, 6'h3F); end
        checks++; if (a !== 16'h0000) begin fails++; $display("FAIL reset_a: got %h want 0000", a); end
        checks++; if (d_out !== 8'h00 || d_oe !== 1'b0) begin fails++; $display("FAIL reset_data: got d_out %h d_oe %b want 00 0", d_out, d_oe); end
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_ack_busy: got %b%b want 00", ack, busy); end
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        checks++; if (dut.state_q !== TS_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, TS_IDLE); end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_memrd();
        logic [5:0]  exp_s [7];
        bus_tstate_t exp_t [7];
        logic rs;
        exp_s = '{6'h3F, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h3F, 6'h3F};
        exp_t = '{TS_T1, TS_T1, TS_T2, TS_T2, TS_T3, TS_T3, TS_IDLE};
        n_wait = 1'b1;
        d_in = 8'hA5;
        begin_cycle(CYC_MEMRD, 16'h4000, 8'h00, 1'b0);
        for (int e = 0; e < 7; e++) begin
            if (e > 0) next_edge(rs);
            checks++; if (strb !== exp_s[e]) begin fails++; $display("FAIL memrd_strobes e%0d: got %b want %b", e, strb, exp_s[e]); end
            checks++; if (dut.state_q !== exp_t[e]) begin fails++; $display("FAIL memrd_state e%0d: got %0d want %0d", e, dut.state_q, exp_t[e]); end
            checks++; if (ack !== (e == 6)) begin fails++; $display("FAIL memrd_ack e%0d: got %b want %b", e, ack, (e == 6)); end
            checks++; if (busy !== 1'b1) begin fails++; $display("FAIL memrd_busy e%0d: got %b want 1", e, busy); end
            checks++; if (a !== 16'h4000) begin fails++; $display("FAIL memrd_addr e%0d: got %h want 4000", e, a); end
            if (e == 4) d_in = 8'h11;
        end
        checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL memrd_rdata: got %h want a5", rdata); end
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL memrd_ack_width: got ack %b busy %b want 0 0", ack, busy); end
    endtask

    task automatic test_m1_back_to_back();
        logic rs;
        logic [5:0]  es;
        bus_tstate_t et;
        logic [7:0]  exp_rd;
        i_reg = 8'h3F;
        n_wait = 1'b1;
        begin_cycle(CYC_M1, 16'h1000, 8'h00, 1'b1);
        checks++; if (strb !== 6'h1F) begin fails++; $display("FAIL m1_first_t1: got %b want %b", strb, 6'h1F); end
        checks++; if (a !== 16'h1000) begin fails++; $display("FAIL m1_first_addr: got %h want 1000", a); end
        for (int n = 0; n < 130; n++) begin
            exp_rd = 8'(n) ^ 8'h5A;
            d_in = exp_rd;
            for (int e = 1; e <= 8; e++) begin
                if (e == 8) begin
                    if (n == 129) req = 1'b0;
                    else addr = 16'h1000 + 16'(n + 1);
                end
                next_edge(rs);
                case (e)
                    1:       begin es = 6'h0B; et = TS_T1; end
                    2, 3:    begin es = 6'h0B; et = TS_T2; end
                    4:       begin es = 6'h3E; et = TS_T3; end
                    5:       begin es = 6'h2E; et = TS_T3; end
                    6:       begin es = 6'h2E; et = TS_T4; end
                    7:       begin es = 6'h3E; et = TS_T4; end
                    default: begin es = (n == 129) ? 6'h3F : 6'h1F; et = (n == 129) ? TS_IDLE : TS_T1; end
                endcase
                checks++; if (strb !== es) begin fails++; $display("FAIL m1_strobes n%0d e%0d: got %b want %b", n, e, strb, es); end
                checks++; if (dut.state_q !== et) begin fails++; $display("FAIL m1_state n%0d e%0d: got %0d want %0d", n, e, dut.state_q, et); end
                checks++; if (ack !== (e == 8)) begin fails++; $display("FAIL m1_ack n%0d e%0d: got %b want %b", n, e, ack, (e == 8)); end
                checks++; if (busy !== 1'b1) begin fails++; $display("FAIL m1_busy n%0d e%0d: got %b want 1", n, e, busy); end
                if (e == 4) begin
                    checks++; if (a !== 16'h3F00 + 16'(n % 128)) begin fails++; $display("FAIL m1_refresh n%0d: got %h want %h", n, a, 16'h3F00 + 16'(n % 128)); end
                end
                if (e == 8) begin
                    checks++; if (rdata !== exp_rd) begin fails++; $display("FAIL m1_rdata n%0d: got %h want %h", n, rdata, exp_rd); end
                    if (n < 129) begin
                        checks++; if (a !== 16'h1000 + 16'(n + 1)) begin fails++; $display("FAIL m1_next_addr n%0d: got %h want %h", n, a, 16'h1000 + 16'(n + 1)); end
                    end
                end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL m1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_iowr();
        logic [5:0]  exp_s [9];
        bus_tstate_t exp_t [9];
        logic        exp_oe [9];
        logic rs;
        exp_s  = '{6'h3F, 6'h3F, 6'h35, 6'h35, 6'h35, 6'h35, 6'h35, 6'h3F, 6'h3F};
        exp_t  = '{TS_T1, TS_T1, TS_T2, TS_T2, TS_TW, TS_TW, TS_T3, TS_T3, TS_IDLE};
        exp_oe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_wait = 1'b1;
        begin_cycle(CYC_IOWR, 16'h00FE, 8'h07, 1'b0);
        addr = 16'h0000;
        wdata = 8'hFF;
        cmd = CYC_MEMRD;
        for (int e = 0; e < 9; e++) begin
            if (e > 0) next_edge(rs);
            checks++; if (strb !== exp_s[e]) begin fails++; $display("FAIL iowr_strobes e%0d: got %b want %b", e, strb, exp_s[e]); end
            checks++; if (dut.state_q !== exp_t[e]) begin fails++; $display("FAIL iowr_state e%0d: got %0d want %0d", e, dut.state_q, exp_t[e]); end
            checks++; if (d_oe !== exp_oe[e]) begin fails++; $display("FAIL iowr_doe e%0d: got %b want %b", e, d_oe, exp_oe[e]); end
            checks++; if (ack !== (e == 8)) begin fails++; $display("FAIL iowr_ack e%0d: got %b want %b", e, ack, (e == 8)); end
            checks++; if (a !== 16'h00FE) begin fails++; $display("FAIL iowr_addr e%0d: got %h want 00fe", e, a); end
            if (e > 0) begin
                checks++; if (d_out !== 8'h07) begin fails++; $display("FAIL iowr_dout e%0d: got %h want 07", e, d_out); end
            end
        end
    endtask

    task automatic test_memwr_wait();
        logic [5:0]  exp_s [11];
        bus_tstate_t exp_t [11];
        logic rs;
        exp_s = '{6'h3F, 6'h2F, 6'h2F, 6'h2D, 6'h2D, 6'h2D, 6'h2D, 6'h2D, 6'h2D, 6'h3F, 6'h3F};
        exp_t = '{TS_T1, TS_T1, TS_T2, TS_T2, TS_TW, TS_TW, TS_TW, TS_TW, TS_T3, TS_T3, TS_IDLE};
        n_wait = 1'b0;
        begin_cycle(CYC_MEMWR, 16'h8000, 8'h3C, 1'b0);
        cmd = CYC_IORD;
        wdata = 8'h00;
        for (int e = 0; e < 11; e++) begin
            if (e > 0) next_edge(rs);
            checks++; if (strb !== exp_s[e]) begin fails++; $display("FAIL memwr_strobes e%0d: got %b want %b", e, strb, exp_s[e]); end
            checks++; if (dut.state_q !== exp_t[e]) begin fails++; $display("FAIL memwr_state e%0d: got %0d want %0d", e, dut.state_q, exp_t[e]); end
            checks++; if (d_oe !== (e >= 1 && e <= 9)) begin fails++; $display("FAIL memwr_doe e%0d: got %b want %b", e, d_oe, (e >= 1 && e <= 9)); end
            checks++; if (ack !== (e == 10)) begin fails++; $display("FAIL memwr_ack e%0d: got %b want %b", e, ack, (e == 10)); end
            if (e > 0) begin
                checks++; if (d_out !== 8'h3C) begin fails++; $display("FAIL memwr_dout e%0d: got %h want 3c", e, d_out); end
            end
            if (e == 5) n_wait = 1'b1;
        end
    endtask

    task automatic test_iord_wait();
        logic [5:0]  exp_s [11];
        bus_tstate_t exp_t [11];
        logic rs;
        exp_s = '{6'h3F, 6'h3F, 6'h33, 6'h33, 6'h33, 6'h33, 6'h33, 6'h33, 6'h33, 6'h3F, 6'h3F};
        exp_t = '{TS_T1, TS_T1, TS_T2, TS_T2, TS_TW, TS_TW, TS_TW, TS_TW, TS_T3, TS_T3, TS_IDLE};
        n_wait = 1'b0;
        d_in = 8'h00;
        begin_cycle(CYC_IORD, 16'h00FF, 8'h00, 1'b0);
        for (int e = 0; e < 11; e++) begin
            if (e > 0) next_edge(rs);
            checks++; if (strb !== exp_s[e]) begin fails++; $display("FAIL iord_strobes e%0d: got %b want %b", e, strb, exp_s[e]); end
            checks++; if (dut.state_q !== exp_t[e]) begin fails++; $display("FAIL iord_state e%0d: got %0d want %0d", e, dut.state_q, exp_t[e]); end
            checks++; if (d_oe !== 1'b0) begin fails++; $display("FAIL iord_doe e%0d: got %b want 0", e, d_oe); end
            checks++; if (ack !== (e == 10)) begin fails++; $display("FAIL iord_ack e%0d: got %b want %b", e, ack, (e == 10)); end
            if (e == 5) n_wait = 1'b1;
            if (e == 8) d_in = 8'h1F;
            if (e == 9) d_in = 8'hEE;
        end
        checks++; if (rdata !== 8'h1F) begin fails++; $display("FAIL iord_rdata: got %h want 1f", rdata); end
    endtask

    task automatic test_bad_cmd();
        logic [5:0] exp_s [7];
        logic rs;
        exp_s = '{6'h3F, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h3F, 6'h3F};
        d_in = 8'h66;
        begin_cycle(3'd7, 16'h1234, 8'h00, 1'b0);
        for (int e = 0; e < 7; e++) begin
            if (e > 0) next_edge(rs);
            checks++; if (strb !== exp_s[e]) begin fails++; $display("FAIL badcmd_strobes e%0d: got %b want %b", e, strb, exp_s[e]); end
            checks++; if (ack !== (e == 6)) begin fails++; $display("FAIL badcmd_ack e%0d: got %b want %b", e, ack, (e == 6)); end
        end
        checks++; if (rdata !== 8'h66) begin fails++; $display("FAIL badcmd_rdata: got %h want 66", rdata); end
    endtask

    task automatic test_req_ignored();
        logic saw_busy;
        saw_busy = 1'b0;
        for (int i = 0; i < 8 && !t_rise; i++) tick();
        cmd = CYC_MEMRD;
        addr = 16'h5555;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b0) begin fails++; $display("FAIL req_ignored_busy: got %b want 0", saw_busy); end
        checks++; if (strb !== 6'h3F) begin fails++; $display("FAIL req_ignored_strobes: got %b want %b", strb, 6'h3F); end
    endtask

    task automatic test_reset_mid_m1();
        logic rs;
        logic saw_ack;
        saw_ack = 1'b0;
        i_reg = 8'h21;
        begin_cycle(CYC_M1, 16'h2222, 8'h00, 1'b0);
        for (int e = 1; e <= 4; e++) next_edge(rs);
        checks++; if (strb !== 6'h3E) begin fails++; $display("FAIL rstmid_t3_strobes: got %b want %b", strb, 6'h3E); end
        checks++; if (a !== 16'h2102) begin fails++; $display("FAIL rstmid_t3_refresh: got %h want 2102", a); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (strb !== 6'h3F) begin fails++; $display("FAIL rstmid_strobes: got %b want %b", strb, 6'h3F); end
        checks++; if (d_oe !== 1'b0 || ack !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: got oe %b ack %b busy %b want 0 0 0", d_oe, ack, busy); end
        checks++; if (a !== 16'h0000 || d_out !== 8'h00 || rdata !== 8'h00) begin fails++; $display("FAIL rstmid_data: got a %h d_out %h rdata %h want 0000 00 00", a, d_out, rdata); end
        checks++; if (dut.state_q !== TS_IDLE) begin fails++; $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, TS_IDLE); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack !== 1'b0) saw_ack = 1'b1;
        end
        checks++; if (saw_ack !== 1'b0) begin fails++; $display("FAIL rstmid_no_ack: got %b want 0", saw_ack); end
        begin_cycle(CYC_M1, 16'h3333, 8'h00, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            next_edge(rs);
            if (e == 4) begin
                checks++; if (a !== 16'h2100) begin fails++; $display("FAIL rstmid_r_cleared: got %h want 2100", a); end
            end
            if (e == 8) begin
                checks++; if (ack !== 1'b1) begin fails++; $display("FAIL rstmid_after_ack: got %b want 1", ack); end
            end
        end
    endtask

    initial begin
        $display("[TB] cpu_bus_master directed test start");
        test_reset();
        test_memrd();
        test_m1_back_to_back();
        test_iowr();
        test_memwr_wait();
        test_iord_wait();
        test_bad_cmd();
        test_req_ignored();
        test_reset_mid_m1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
